// File: rtl/mc_data_path.sv
// mc_data_path: multi-cycle RV32I-subset core with one unified memory port.
// Define MC_DATA_PATH_TRAP_EN to halt with a sticky trap on illegal instructions.
module mc_data_path #(
  parameter int              WIDTH    = 32,
  parameter int              NREGS    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [WIDTH-1:0] pc_o,
  output logic             retire,
  output logic             trap
);

  localparam int RAW = (NREGS == 16) ? 4 : 5;

  localparam logic [6:0] OP_R = 7'h33;
  localparam logic [6:0] OP_I = 7'h13;
  localparam logic [6:0] OP_L = 7'h03;
  localparam logic [6:0] OP_S = 7'h23;
  localparam logic [6:0] OP_B = 7'h63;
  localparam logic [6:0] OP_J = 7'h6F;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [WIDTH-1:0] rf_q [NREGS];
`ifdef MC_DATA_PATH_TRAP_EN
  logic             trap_q, trap_d;
`endif

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic is_r, is_i, is_lw, is_sw, is_br, is_jal;
  logic bad_idx, legal, taken, retire_c;
  logic rf_we;
  logic [WIDTH-1:0] rf_wdata, imm, op2, alu_res;
  logic [WIDTH-1:0] rs1_val, rs2_val;

  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1[RAW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2[RAW-1:0]];

  // Instruction class decode and legality
  always_comb begin
    is_r   = (opc == OP_R) && (f3 != 3'b011) &&
             ((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'b000)));
    is_i   = (opc == OP_I) &&
             (f3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111});
    is_lw  = (opc == OP_L) && (f3 == 3'b010);
    is_sw  = (opc == OP_S) && (f3 == 3'b010);
    is_br  = (opc == OP_B) && (f3 inside {3'b000, 3'b001, 3'b100});
    is_jal = (opc == OP_J);
    bad_idx = (NREGS == 16) &&
              (((is_r | is_i | is_lw | is_jal) && rd[4]) ||
               ((is_r | is_i | is_lw | is_sw | is_br) && rs1[4]) ||
               ((is_r | is_sw | is_br) && rs2[4]));
    legal = (is_r | is_i | is_lw | is_sw | is_br | is_jal) && !bad_idx;
  end

  // Sign-extended immediate by format
  always_comb begin
    imm = {{(WIDTH-12){ir_q[31]}}, ir_q[31:20]};
    unique case (1'b1)
      is_sw:  imm = {{(WIDTH-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      is_br:  imm = {{(WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7],
                     ir_q[30:25], ir_q[11:8], 1'b0};
      is_jal: imm = {{(WIDTH-21){ir_q[31]}}, ir_q[31], ir_q[19:12],
                     ir_q[20], ir_q[30:21], 1'b0};
      default: ;
    endcase
  end

  // ALU result and branch condition
  always_comb begin
    op2     = is_r ? b_q : imm;
    alu_res = '0;
    if (is_lw || is_sw) begin
      alu_res = a_q + imm;
    end else if (is_jal) begin
      alu_res = pc_q + WIDTH'(4);
    end else begin
      case (f3)
        3'b000: alu_res = (is_r && f7[5]) ? a_q - op2 : a_q + op2;
        3'b001: alu_res = a_q << op2[4:0];
        3'b010: alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(op2)};
        3'b100: alu_res = a_q ^ op2;
        3'b101: alu_res = a_q >> op2[4:0];
        3'b110: alu_res = a_q | op2;
        default: alu_res = a_q & op2;
      endcase
    end
    case (f3)
      3'b000:  taken = (a_q == b_q);
      3'b001:  taken = (a_q != b_q);
      3'b100:  taken = $signed(a_q) < $signed(b_q);
      default: taken = 1'b0;
    endcase
  end

  // FSM next state and datapath register updates
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    retire_c = 1'b0;
`ifdef MC_DATA_PATH_TRAP_EN
    trap_d   = trap_q;
`endif
    unique case (state_q)
      FETCH: if (mem_ack) begin
        ir_d    = mem_rdata;
        state_d = DECODE;
      end
      DECODE: begin
        a_d     = rs1_val;
        b_d     = rs2_val;
        state_d = EXEC;
`ifdef MC_DATA_PATH_TRAP_EN
        if (!legal) begin
          state_d = HALT;
          trap_d  = 1'b1;
        end
`endif
      end
      EXEC: begin
        alu_d = alu_res;
        if (!legal) begin
          pc_d     = pc_q + WIDTH'(4);
          retire_c = 1'b1;
          state_d  = FETCH;
        end else if (is_lw || is_sw) begin
          state_d = MEM;
        end else if (is_br) begin
          pc_d     = taken ? pc_q + imm : pc_q + WIDTH'(4);
          retire_c = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d = WB;
        end
      end
      MEM: if (mem_ack) begin
        if (is_sw) begin
          pc_d     = pc_q + WIDTH'(4);
          retire_c = 1'b1;
          state_d  = FETCH;
        end else begin
          mdr_d   = mem_rdata;
          state_d = WB;
        end
      end
      WB: begin
        rf_we    = (rd != 5'd0);
        rf_wdata = is_lw ? mdr_q : (is_jal ? pc_q + WIDTH'(4) : alu_q);
        pc_d     = is_jal ? pc_q + imm : pc_q + WIDTH'(4);
        retire_c = 1'b1;
        state_d  = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // State registers and register file, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
`ifdef MC_DATA_PATH_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (rf_we) rf_q[rd[RAW-1:0]] <= rf_wdata;
`ifdef MC_DATA_PATH_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  // Bus outputs come from the registered state; reset forces them idle
  always_comb begin
    mem_req   = !reset_n && ((state_q == FETCH) || (state_q == MEM));
    mem_we    = !reset_n && (state_q == MEM) && is_sw;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset_n && state_q == FETCH) mem_addr = pc_q;
    if (!reset_n && state_q == MEM) begin
      mem_addr  = alu_q;
      mem_wdata = b_q;
    end
    retire = !reset_n && retire_c;
    pc_o   = reset_n ? RESET_PC : pc_q;
`ifdef MC_DATA_PATH_TRAP_EN
    trap   = trap_q;
`else
    trap   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mc_data_path.sv
// tb_mc_data_path: program-driven bench for mc_data_path.
// Scoreboard queues hold expected bus reads, writes and early retire cycles.
module tb_mc_data_path;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_req, mem_we, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
  logic        mem_ack;

  logic        ack_r = 1'b0;
  logic [31:0] rdata_r = '0;
  logic        r_req, r_we, r_ret, r_trap;
  logic [31:0] r_addr, r_wdata, r_pc;

  always #5 clk = ~clk;

  mc_data_path #(.WIDTH(32), .NREGS(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc_o(pc_o), .retire(retire), .trap(trap)
  );

  mc_data_path #(.WIDTH(32), .NREGS(32), .RESET_PC(32'h100)) dut_r (
    .clk(clk), .reset_n(reset_n),
    .mem_req(r_req), .mem_we(r_we),
    .mem_addr(r_addr), .mem_wdata(r_wdata),
    .mem_rdata(rdata_r), .mem_ack(ack_r),
    .pc_o(r_pc), .retire(r_ret), .trap(r_trap)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

`ifdef MC_DATA_PATH_TRAP_EN
  localparam int EXP_RET = 29;
`else
  localparam int EXP_RET = 30;
`endif

  logic [31:0] mem [0:63];
  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];
  int          exp_ret[$];
  int n_vec = 0, n_bad = 0;
  int cyc = 0, ret_cnt = 0, extra_rd = 0, ret_at_empty = -1;
  int dly = 0, wcnt = 0;
  logic [31:0] s_addr, s_wd;
  logic        s_we;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int f7, rs2, rs1, f3, rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, rs1, f3, rd, op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, rs2, rs1);
    logic [11:0] t;
    t = 12'(imm);
    return {t[11:5], 5'(rs2), 5'(rs1), 3'b010, t[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, rs2, rs1, f3);
    logic [12:0] t;
    t = 13'(imm);
    return {t[12], t[10:5], 5'(rs2), 5'(rs1), 3'(f3), t[4:1], t[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, rd);
    logic [20:0] t;
    t = 21'(imm);
    return {t[20], t[10:1], t[11], t[19:12], 5'(rd), 7'h6F};
  endfunction

  // Memory responder and bus monitor
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        mem_ack = 1'b0;
        wcnt    = 0;
        cyc     = 0;
      end else begin
        cyc++;
        if (mem_req) begin
          if (wcnt == 0) begin
            s_addr = mem_addr;
            s_we   = mem_we;
            s_wd   = mem_wdata;
          end else begin
            check("hold_addr", mem_addr, s_addr);
            check("hold_we", {31'b0, mem_we}, {31'b0, s_we});
            check("hold_wdata", mem_wdata, s_wd);
          end
          if (wcnt >= dly) begin
            mem_ack = 1'b1;
            wcnt    = 0;
            if (mem_we) begin
              check("wr_expected", {31'b0, exp_wr.size() != 0}, 32'd1);
              if (exp_wr.size() != 0) begin
                wr_t w;
                w = exp_wr.pop_front();
                check("wr_addr", mem_addr, w.a);
                check("wr_data", mem_wdata, w.d);
              end
              mem[mem_addr[7:2]] = mem_wdata;
            end else begin
              if (exp_rd.size() != 0) begin
                check("rd_addr", mem_addr, exp_rd.pop_front());
                if (exp_rd.size() == 0) ret_at_empty = ret_cnt;
              end else begin
                extra_rd++;
              end
              mem_rdata = mem[mem_addr[7:2]];
            end
          end else begin
            mem_ack = 1'b0;
            wcnt++;
          end
        end else begin
          mem_ack = 1'b0;
          wcnt    = 0;
        end
        #1;
        if (retire) begin
          ret_cnt++;
          if (exp_ret.size() != 0) check("ret_cycle", cyc, exp_ret.pop_front());
          if (ret_cnt >= 3) dly = 3;
        end
      end
    end
  end

  // Program load, reset sequence and end-of-run checks
  initial begin
    reset_n = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = enc_i(5, 0, 0, 1, 'h13);
    mem[1]  = enc_i(7, 0, 0, 2, 'h13);
    mem[2]  = enc_r(0, 2, 1, 0, 3);
    mem[3]  = enc_s('h80, 3, 0);
    mem[4]  = enc_i('h80, 0, 2, 4, 'h03);
    mem[5]  = enc_s('h84, 4, 0);
    mem[6]  = enc_i(1, 6, 0, 6, 'h13);
    mem[7]  = enc_i(1, 0, 0, 7, 'h13);
    mem[8]  = enc_b(-8, 7, 6, 0);
    mem[9]  = enc_i(-1, 0, 0, 8, 'h13);
    mem[10] = enc_b(8, 0, 8, 4);
    mem[11] = enc_i(1, 0, 0, 9, 'h13);
    mem[12] = enc_j('h10, 5);
    mem[13] = 32'h7F;
    mem[14] = 32'h7F;
    mem[15] = 32'h7F;
    mem[16] = enc_b(8, 1, 1, 1);
    mem[17] = enc_i(9, 0, 0, 0, 'h13);
    mem[18] = enc_s('h88, 0, 0);
    mem[19] = enc_s('h8C, 5, 0);
    mem[20] = enc_r('h20, 1, 2, 0, 10);
    mem[21] = enc_r(0, 1, 8, 2, 11);
    mem[22] = enc_r(0, 1, 8, 5, 12);
    mem[23] = enc_r(0, 2, 1, 1, 13);
    mem[24] = enc_i(-1, 1, 4, 14, 'h13);
    for (int i = 0; i < 5; i++) mem[25+i] = enc_s('h90 + 4*i, 10 + i, 0);
    mem[30] = 32'h0000007F;
    mem[31] = enc_j(0, 0);

    exp_rd = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h80, 32'h14,
               32'h18, 32'h1C, 32'h20, 32'h18, 32'h1C, 32'h20, 32'h24,
               32'h28, 32'h30, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50,
               32'h54, 32'h58, 32'h5C, 32'h60, 32'h64, 32'h68, 32'h6C,
               32'h70, 32'h74, 32'h78};
`ifndef MC_DATA_PATH_TRAP_EN
    exp_rd.push_back(32'h7C);
`endif
    exp_wr.push_back('{32'h80, 32'd12});
    exp_wr.push_back('{32'h84, 32'd12});
    exp_wr.push_back('{32'h88, 32'd0});
    exp_wr.push_back('{32'h8C, 32'h34});
    exp_wr.push_back('{32'h90, 32'd2});
    exp_wr.push_back('{32'h94, 32'd1});
    exp_wr.push_back('{32'h98, 32'h07FF_FFFF});
    exp_wr.push_back('{32'h9C, 32'h280});
    exp_wr.push_back('{32'hA0, 32'hFFFF_FFFA});
    exp_ret = '{4, 8, 12};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_trap", {31'b0, trap}, 32'd0);
    check("rst_r_req", {31'b0, r_req}, 32'd0);
    check("rst_r_we", {31'b0, r_we}, 32'd0);
    check("rst_r_addr", r_addr, 32'd0);
    check("rst_r_wdata", r_wdata, 32'd0);
    check("rst_r_ret", {31'b0, r_ret}, 32'd0);
    check("rst_r_trap", {31'b0, r_trap}, 32'd0);
    check("rst_r_pc", r_pc, 32'h100);

    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    #2;
    check("rel_r_req", {31'b0, r_req}, 32'd1);
    check("rel_r_addr", r_addr, 32'h100);

    for (int k = 0; k < 3000 && exp_rd.size() != 0; k++) @(posedge clk);
    check("rd_drain", exp_rd.size(), 32'd0);
    check("wr_drain", exp_wr.size(), 32'd0);
    check("ret_drain", exp_ret.size(), 32'd0);
    check("ret_count", ret_at_empty, EXP_RET);

    repeat (30) @(posedge clk);
    @(negedge clk);
    #2;
`ifdef MC_DATA_PATH_TRAP_EN
    check("trap_set", {31'b0, trap}, 32'd1);
    check("trap_no_req", extra_rd, 32'd0);
    check("trap_no_ret", ret_cnt, EXP_RET);
`else
    check("nop_no_trap", {31'b0, trap}, 32'd0);
    check("nop_continues", {31'b0, extra_rd != 0}, 32'd1);
`endif

    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    check("rst2_trap", {31'b0, trap}, 32'd0);
    check("rst2_req", {31'b0, mem_req}, 32'd0);
    check("rst2_pc", pc_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
